turnstile_fare_controller: RTL and testbench

Fare-collection controller that sequences a single turnstile gate. It accumulates coin credit and unlocks the gate once credit reaches the fare. It re-locks on passage or timeout, counts passages, flags forced entry, and supports a maintenance hold-open mode. It sits between the coin acceptor and rotation sensor inputs and the gate lock actuator.

---
 rtl/turnstile_fare_controller_if.sv | 28 ++
 rtl/turnstile_fare_controller.sv | 141 ++++++++++++++
 tb/tb_turnstile_fare_controller.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turnstile_fare_controller_if.sv
// Turnstile I/O bundle: coin/rotation/service/alarm-clear inputs
// and gate-lock, credit, count, alarm and refund outputs.
interface turnstile_fare_controller_if #(
  parameter int CREDIT_WIDTH = 4,
  parameter int COUNT_WIDTH  = 16
);
  logic                    i_Coin;
  logic                    i_Push;
  logic                    i_Service;
  logic                    i_Alarm_Clr;
  logic                    o_Locked;
  logic [CREDIT_WIDTH-1:0] o_Credit;
  logic [COUNT_WIDTH-1:0]  o_Pass_Count;
  logic                    o_Alarm;
  logic                    o_Refund;

  modport master (
    output i_Coin, i_Push, i_Service, i_Alarm_Clr,
    input  o_Locked, o_Credit, o_Pass_Count,
    input  o_Alarm, o_Refund
  );

  modport slave (
    input  i_Coin, i_Push, i_Service, i_Alarm_Clr,
    output o_Locked, o_Credit, o_Pass_Count,
    output o_Alarm, o_Refund
  );
endinterface

// File: rtl/turnstile_fare_controller.sv
// Turnstile fare controller: credit accumulation, unlock/relock,
// passage count, forced-entry alarm, maintenance hold-open.
// Ports: i_Clk, i_Reset (async, active-high), bus (slave modport).
module turnstile_fare_controller #(
  parameter int FARE           = 2,
  parameter int TIMEOUT_CYCLES = 25000000,
  parameter int CREDIT_WIDTH   = 4,
  parameter int COUNT_WIDTH    = 16
) (
  input logic                         i_Clk,
  input logic                         i_Reset,
  turnstile_fare_controller_if.slave  bus
);

  localparam int CW = CREDIT_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [CW:0] FARE_W =
    (CW+1)'(FARE);
  localparam logic [CW:0] MAX_W =
    (CW+1)'((1 << CW) - 1);
  localparam logic [TW-1:0] T_LOAD =
    TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOCKED,
    S_UNLOCKED,
    S_ALARM,
    S_SERVICE
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CW-1:0]          credit_q, credit_d;
  logic [COUNT_WIDTH-1:0] pass_q, pass_d;
  logic                   locked_q, locked_d;
  logic                   alarm_q, alarm_d;
  logic                   refund_q, refund_d;

  logic [CW:0] debit;
  logic [CW:0] restore;
  logic [CW:0] sum;
  logic [CW:0] base;
  logic        coin_add;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pass_d  = pass_q;
    debit   = '0;
    restore = '0;

    unique case (state_q)
      S_LOCKED: begin
        if (bus.i_Service) begin
          state_d = S_SERVICE;
          timer_d = '0;
        end else if (bus.i_Push) begin
          state_d = S_ALARM;
        end else if ({1'b0, credit_q} >= FARE_W) begin
          state_d = S_UNLOCKED;
          debit   = FARE_W;
          timer_d = T_LOAD;
        end
      end
      S_UNLOCKED: begin
        if (bus.i_Service) begin
          state_d = S_SERVICE;
          timer_d = '0;
        end else if (bus.i_Push) begin
          state_d = S_LOCKED;
          pass_d  = pass_q + 1'b1;
        end else if (timer_q == '0) begin
          // Unused fare goes back to the rider.
          state_d = S_LOCKED;
          restore = FARE_W;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_ALARM: begin
        if (bus.i_Service) begin
          state_d = S_SERVICE;
          timer_d = '0;
        end else if (bus.i_Alarm_Clr) begin
          state_d = S_LOCKED;
        end
      end
      S_SERVICE: begin
        timer_d = '0;
        if (!bus.i_Service) begin
          state_d = S_LOCKED;
        end
      end
      default: begin
        state_d = S_LOCKED;
        timer_d = '0;
      end
    endcase

    // Debit and restore never coincide, so no underflow;
    // the restore may overshoot and is clamped.
    sum  = {1'b0, credit_q} - debit + restore;
    base = (sum > MAX_W) ? MAX_W : sum;

    coin_add = bus.i_Coin && (base < MAX_W);
    credit_d = base[CW-1:0] + {{(CW-1){1'b0}}, coin_add};
    refund_d = bus.i_Coin && !coin_add;

    locked_d = !((state_d == S_UNLOCKED) ||
                 (state_d == S_SERVICE));
    alarm_d  = (state_d == S_ALARM);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= S_LOCKED;
      timer_q  <= '0;
      credit_q <= '0;
      pass_q   <= '0;
      locked_q <= 1'b1;
      alarm_q  <= 1'b0;
      refund_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      credit_q <= credit_d;
      pass_q   <= pass_d;
      locked_q <= locked_d;
      alarm_q  <= alarm_d;
      refund_q <= refund_d;
    end
  end

  assign bus.o_Locked     = locked_q;
  assign bus.o_Credit     = credit_q;
  assign bus.o_Pass_Count = pass_q;
  assign bus.o_Alarm      = alarm_q;
  assign bus.o_Refund     = refund_q;

endmodule

// File: tb/tb_turnstile_fare_controller.sv
// Scoreboard bench for turnstile_fare_controller: directed and
// random stimulus against an integer reference model.
module tb_turnstile_fare_controller;

  localparam int FARE  = 2;
  localparam int TOUT  = 8;
  localparam int CW    = 4;
  localparam int NW    = 16;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int NMASK = (1 << NW) - 1;

  localparam int M_LOCK = 0;
  localparam int M_UNL  = 1;
  localparam int M_ALM  = 2;
  localparam int M_SVC  = 3;

  typedef struct {
    int locked;
    int credit;
    int pass;
    int alarm;
    int refund;
  } exp_t;

  logic clk;
  logic rst;

  turnstile_fare_controller_if #(
    .CREDIT_WIDTH(CW),
    .COUNT_WIDTH (NW)
  ) bus ();

  turnstile_fare_controller #(
    .FARE          (FARE),
    .TIMEOUT_CYCLES(TOUT),
    .CREDIT_WIDTH  (CW),
    .COUNT_WIDTH   (NW)
  ) dut (
    .i_Clk  (clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  int m_mode;
  int m_credit;
  int m_timer;
  int m_pass;

  task automatic chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_LOCK;
    m_credit = 0;
    m_timer  = 0;
    m_pass   = 0;
  endtask

  // One clock of the fare rules, in plain integers.
  task automatic model_step(
    input bit c, input bit p, input bit s, input bit a,
    output exp_t e
  );
    int bal;
    int ref_now;
    bal = m_credit;
    ref_now = 0;
    case (m_mode)
      M_LOCK: begin
        if (s) m_mode = M_SVC;
        else if (p) m_mode = M_ALM;
        else if (m_credit >= FARE) begin
          m_mode = M_UNL;
          bal = bal - FARE;
          m_timer = TOUT - 1;
        end
      end
      M_UNL: begin
        if (s) m_mode = M_SVC;
        else if (p) begin
          m_mode = M_LOCK;
          m_pass = (m_pass + 1) & NMASK;
        end else if (m_timer == 0) begin
          m_mode = M_LOCK;
          bal = bal + FARE;
        end else m_timer--;
      end
      M_ALM: begin
        if (s) m_mode = M_SVC;
        else if (a) m_mode = M_LOCK;
      end
      default: begin
        if (!s) m_mode = M_LOCK;
      end
    endcase
    if (bal > CMAX) bal = CMAX;
    if (c) begin
      if (bal < CMAX) bal++;
      else ref_now = 1;
    end
    m_credit = bal;
    e.locked = (m_mode == M_UNL || m_mode == M_SVC) ? 0 : 1;
    e.credit = m_credit;
    e.pass   = m_pass;
    e.alarm  = (m_mode == M_ALM) ? 1 : 0;
    e.refund = ref_now;
  endtask

  task automatic cyc(input bit c, input bit p,
                     input bit s, input bit a);
    exp_t e;
    @(negedge clk);
    bus.i_Coin      = c;
    bus.i_Push      = p;
    bus.i_Service   = s;
    bus.i_Alarm_Clr = a;
    model_step(c, p, s, a, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  // Reset asserted between edges must act at once.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_locked", int'(bus.o_Locked), 1);
    chk("async_credit", int'(bus.o_Credit), 0);
    chk("async_pass", int'(bus.o_Pass_Count), 0);
    chk("async_alarm", int'(bus.o_Alarm), 0);
    model_reset();
    @(negedge clk);
    bus.i_Coin      = 1'b0;
    bus.i_Push      = 1'b0;
    bus.i_Service   = 1'b0;
    bus.i_Alarm_Clr = 1'b0;
    rst = 1'b0;
  endtask

  // Monitor: every edge the DUT presents fresh outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("locked", int'(bus.o_Locked), e.locked);
        chk("credit", int'(bus.o_Credit), e.credit);
        chk("pass", int'(bus.o_Pass_Count), e.pass);
        chk("alarm", int'(bus.o_Alarm), e.alarm);
        chk("refund", int'(bus.o_Refund), e.refund);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end, limit %0d",
             2000000);
    $fatal(1, "watchdog");
  end

  initial begin
    bit svc;
    rst = 1'b1;
    bus.i_Coin      = 1'b0;
    bus.i_Push      = 1'b0;
    bus.i_Service   = 1'b0;
    bus.i_Alarm_Clr = 1'b0;
    model_reset();
    #1;
    chk("rst_locked", int'(bus.o_Locked), 1);
    chk("rst_credit", int'(bus.o_Credit), 0);
    chk("rst_pass", int'(bus.o_Pass_Count), 0);
    chk("rst_alarm", int'(bus.o_Alarm), 0);
    chk("rst_refund", int'(bus.o_Refund), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic paid entry.
    cyc(1, 0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 0);
    idle(3);
    cyc(0, 1, 0, 0);
    idle(2);

    // Timeout, restore, re-unlock, then pass.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    idle(13);
    cyc(0, 1, 0, 0);
    idle(2);

    // Forced entry, coins in alarm, clear, unlock.
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 1);
    idle(3);
    cyc(0, 1, 0, 0);
    idle(2);

    // Saturation in alarm: 16 coins from credit 1.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    idle(2);
    // Drain credit through timeouts with coins in flight.
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);
    idle(30);

    // Push at every point of the unlock window,
    // including the expiry cycle and beyond it.
    for (int d = 0; d < TOUT + 2; d++) begin
      async_reset();
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      idle(1);
      idle(d);
      cyc(0, 1, 0, 0);
      idle(2);
    end

    // Coin on the unlock cycle.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    idle(2);
    cyc(0, 1, 0, 0);

    // Service from alarm and from unlocked.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 1, 1, 1);
    idle(2);
    cyc(1, 0, 0, 0);
    idle(2);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    idle(3);
    cyc(0, 0, 0, 1);

    // Reset mid-unlock with credit pending.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0);
    async_reset();
    idle(2);

    // Random traffic.
    svc = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) svc = ~svc;
      cyc($urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 4,
          svc,
          $urandom_range(0, 99) < 8);
      if ($urandom_range(0, 999) == 0) async_reset();
    end
    idle(3);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
